tank_key_ctrl: RTL
==================

TANK_KEY_CTRL -- requirements
Module: tank_key_ctrl

Interface
REQ-001 Parameter MOVE_PERIOD, default 2500000, cycles between successive move steps while a direction key is held; legal range 2..2^26-1.
REQ-002 Parameter FIRE_COOLDOWN, default 25000000, minimum cycles between fire pulses of one tank; legal range 2..2^26-1.
REQ-003 clk  input  1  system clock; every register updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 key_data  input  10  scan code from the PS/2 decoder, {expand, break, code[7:0]}; valid only while key_ready=1.
REQ-006 key_ready  input  1  one-cycle strobe marking key_data valid.
REQ-007 tank1_dir, tank2_dir  output  2 each  facing direction: 0=up, 1=down, 2=left, 3=right.
REQ-008 tank1_moving, tank2_moving  output  1 each  at least one direction key of that tank is held.
REQ-009 tank1_step, tank2_step  output  1 each  one-cycle pulse commanding one movement step.
REQ-010 tank1_fire, tank2_fire  output  1 each  one-cycle pulse commanding one shell launch.

Function
REQ-011 Key map, expand=0 only: tank1 up 1D, down 1B, left 1C, right 23, fire 29; tank2 up 43, down 42, left 3B, right 4B, fire 5A.
REQ-012 Codes with expand=1 and unmapped codes are ignored and change no state.
REQ-013 Each tank keeps a 5-bit held map (4 directions plus fire): a make (break=0) sets the bit and a break (break=1) clears it, both on the edge that samples key_ready=1.
REQ-014 A direction make, including a typematic repeat, sets dir to that key in the cycle after key_ready (last-pressed wins).
REQ-015 A break of the key matching the current dir, with other direction keys still held, sets dir to the remaining key by fixed priority up>down>left>right; with none held, dir keeps its value.
REQ-016 moving is the OR of the four direction held bits, registered, valid one cycle after key_ready.
REQ-017 Each tank has a 26-bit step counter: on moving 0->1, step pulses in the same cycle moving first reads 1 and the counter loads MOVE_PERIOD-1.
REQ-018 While moving=1 the step counter decrements each cycle; at 0, step pulses and the counter reloads MOVE_PERIOD-1.
REQ-019 When moving=0 the step counter holds at 0 and step stays 0.
REQ-020 Each tank has a 26-bit cooldown counter that decrements to 0 and saturates there.
REQ-021 A fire make from released state (held bit was 0) while cooldown==0: fire pulses in the next cycle and cooldown loads FIRE_COOLDOWN-1.
REQ-022 A fire make while cooldown!=0, or any typematic repeat of an already-held fire key, is dropped; it is never queued.
REQ-023 The two tanks are fully independent; one key_ready changes at most one tank's state.
REQ-024 If a key event and a counter expiry occur in the same cycle, both take effect; a break that drops moving to 0 suppresses that cycle's step.

Reset
REQ-025 With rst=1 at a clock edge: held maps, counters, moving, step and fire go to 0; tank1_dir=0 (up); tank2_dir=1 (down).
REQ-026 rst overrides key_ready in the same cycle; any in-progress cooldown or step period is discarded.
REQ-027 Keys held across reset count as released until a new make is received.

Configuration
REQ-028 Macro TANK_AUTOFIRE_EN defined: while the fire held bit is 1 and cooldown reaches 0, fire pulses and cooldown reloads FIRE_COOLDOWN-1, giving one shot every FIRE_COOLDOWN cycles while held.
REQ-029 Macro TANK_AUTOFIRE_EN undefined: fire pulses only per REQ-021, and no auto-repeat logic is present.

Verification (MOVE_PERIOD=4, FIRE_COOLDOWN=8)
REQ-030 Reset, then make 1D at cycle 10 -> tank1_dir=0, moving=1, step=1 at cycle 11; step again at cycles 15 and 19; tank2 outputs stay unchanged.
REQ-031 Make 1C, then make 23, then break 23 -> dir goes 2, then 3, then 2; a final break 1C gives moving=0, step stays 0, and dir stays 2.
REQ-032 Make 29 at cycle 20 -> tank1_fire=1 at cycle 21; break 29, then make 29 at cycle 25 -> no pulse; make 29 at cycle 30 after a break -> pulse at cycle 31.
REQ-033 Typematic: three makes of 5A with no break -> exactly one tank2_fire pulse; with TANK_AUTOFIRE_EN, holding 5A for 30 cycles gives pulses 8 cycles apart.
REQ-034 Expand code 0x21D, then 0x01D with rst=1 in the same cycle -> no state change; after reset all outputs 0, tank2_dir=1.
REQ-035 Same cycle: tank2 step counter expires and key_ready carries break 42 (tank2's last held direction) -> no tank2_step; tank2_moving=0 next cycle.

Source files
------------

// File: rtl/tank_key_ctrl_if.sv
// Key-event and tank-command bundle between the PS/2 front end and the tank controller.
// The master drives scan codes; the slave (tank_key_ctrl) drives per-tank movement and fire commands.
interface tank_key_ctrl_if;
   logic [9:0] key_data;
   logic       key_ready;
   logic [1:0] tank1_dir;
   logic [1:0] tank2_dir;
   logic       tank1_moving;
   logic       tank2_moving;
   logic       tank1_step;
   logic       tank2_step;
   logic       tank1_fire;
   logic       tank2_fire;

   modport master (
      output key_data, key_ready,
      input  tank1_dir, tank2_dir, tank1_moving, tank2_moving,
             tank1_step, tank2_step, tank1_fire, tank2_fire
   );

   modport slave (
      input  key_data, key_ready,
      output tank1_dir, tank2_dir, tank1_moving, tank2_moving,
             tank1_step, tank2_step, tank1_fire, tank2_fire
   );
endinterface

// File: rtl/tank_key_ctrl.sv
// Two-tank keyboard controller: held-key tracking, facing direction, move-step and fire pulses.
// Optional macro TANK_AUTOFIRE_EN repeats fire every FIRE_COOLDOWN cycles while the fire key is held.
module tank_key_ctrl #(
   parameter int MOVE_PERIOD   = 2500000,
   parameter int FIRE_COOLDOWN = 25000000
) (
   input  logic           clk,
   input  logic           rst,
   tank_key_ctrl_if.slave bus
);
   localparam logic [25:0] MOVE_RELOAD = 26'(MOVE_PERIOD - 1);
   localparam logic [25:0] FIRE_RELOAD = 26'(FIRE_COOLDOWN - 1);
   localparam logic [2:0]  IDX_FIRE    = 3'd4;

   // Returns {hit, index}; index 0..3 = up/down/left/right, 4 = fire.
   function automatic logic [3:0] decode_key(input logic [7:0] code, input logic tank);
      logic [3:0] r;
      r = 4'b0000;
      if (!tank) begin
         case (code)
            8'h1D:   r = 4'b1000;
            8'h1B:   r = 4'b1001;
            8'h1C:   r = 4'b1010;
            8'h23:   r = 4'b1011;
            8'h29:   r = 4'b1100;
            default: r = 4'b0000;
         endcase
      end else begin
         case (code)
            8'h43:   r = 4'b1000;
            8'h42:   r = 4'b1001;
            8'h3B:   r = 4'b1010;
            8'h4B:   r = 4'b1011;
            8'h5A:   r = 4'b1100;
            default: r = 4'b0000;
         endcase
      end
      return r;
   endfunction

   function automatic logic [1:0] pick_dir(input logic [3:0] held_dirs);
      logic [1:0] d;
      if (held_dirs[0])      d = 2'd0;
      else if (held_dirs[1]) d = 2'd1;
      else if (held_dirs[2]) d = 2'd2;
      else                   d = 2'd3;
      return d;
   endfunction

   function automatic logic [25:0] sat_dec(input logic [25:0] v);
      return (v == 26'd0) ? 26'd0 : v - 26'd1;
   endfunction

   logic                  vld_p0;
   logic                  brk_p0;
   logic [1:0][3:0]       dec_p0;
   logic [1:0]            ev_hit_p0;
   logic [1:0][2:0]       ev_idx_p0;
   logic [1:0][4:0]       held_p0;
   logic [1:0][1:0]       dir_p0;
   logic [1:0]            moving_p0;
   logic [1:0]            fire_p0;

   logic [1:0][4:0]       held_p1;
   logic [1:0][1:0]       dir_p1;
   logic [1:0]            moving_p1;
   logic [1:0]            step_p1;
   logic [1:0]            fire_p1;
   logic [1:0][25:0]      step_cnt_p1;
   logic [1:0][25:0]      cool_cnt_p1;

   // Stage p0: decode the key event against the registered state.
   always_comb begin
      vld_p0    = bus.key_ready & ~bus.key_data[9];
      brk_p0    = bus.key_data[8];
      dec_p0    = '0;
      ev_hit_p0 = '0;
      ev_idx_p0 = '0;
      held_p0   = held_p1;
      dir_p0    = dir_p1;
      moving_p0 = '0;
      fire_p0   = '0;
      for (int t = 0; t < 2; t++) begin
         dec_p0[t]    = decode_key(bus.key_data[7:0], 1'(t));
         ev_hit_p0[t] = vld_p0 & dec_p0[t][3];
         ev_idx_p0[t] = dec_p0[t][2:0];
         if (ev_hit_p0[t]) begin
            held_p0[t][ev_idx_p0[t]] = ~brk_p0;
         end
         if (ev_hit_p0[t] && ev_idx_p0[t] != IDX_FIRE) begin
            if (!brk_p0) begin
               dir_p0[t] = ev_idx_p0[t][1:0];
            end else if (ev_idx_p0[t][1:0] == dir_p1[t] && |held_p0[t][3:0]) begin
               dir_p0[t] = pick_dir(held_p0[t][3:0]);
            end
         end
         moving_p0[t] = |held_p0[t][3:0];
`ifdef TANK_AUTOFIRE_EN
         // Covers both a fresh make and the held-key repeat once cooldown expires.
         fire_p0[t] = held_p0[t][4] & (cool_cnt_p1[t] == 26'd0);
`else
         fire_p0[t] = ev_hit_p0[t] & ~brk_p0 & (ev_idx_p0[t] == IDX_FIRE)
                      & ~held_p1[t][4] & (cool_cnt_p1[t] == 26'd0);
`endif
      end
   end

   // Stage p1: registered tank state, counters and command pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         held_p1     <= '0;
         dir_p1      <= {2'd1, 2'd0};
         moving_p1   <= '0;
         step_p1     <= '0;
         fire_p1     <= '0;
         step_cnt_p1 <= '0;
         cool_cnt_p1 <= '0;
      end else begin
         held_p1   <= held_p0;
         dir_p1    <= dir_p0;
         moving_p1 <= moving_p0;
         fire_p1   <= fire_p0;
         for (int t = 0; t < 2; t++) begin
            // A break that stops the tank wins over a coincident counter expiry.
            if (!moving_p0[t]) begin
               step_p1[t]     <= 1'b0;
               step_cnt_p1[t] <= 26'd0;
            end else if (!moving_p1[t] || step_cnt_p1[t] == 26'd0) begin
               step_p1[t]     <= 1'b1;
               step_cnt_p1[t] <= MOVE_RELOAD;
            end else begin
               step_p1[t]     <= 1'b0;
               step_cnt_p1[t] <= step_cnt_p1[t] - 26'd1;
            end
            if (fire_p0[t]) begin
               cool_cnt_p1[t] <= FIRE_RELOAD;
            end else begin
               cool_cnt_p1[t] <= sat_dec(cool_cnt_p1[t]);
            end
         end
      end
   end

   assign bus.tank1_dir    = dir_p1[0];
   assign bus.tank2_dir    = dir_p1[1];
   assign bus.tank1_moving = moving_p1[0];
   assign bus.tank2_moving = moving_p1[1];
   assign bus.tank1_step   = step_p1[0];
   assign bus.tank2_step   = step_p1[1];
   assign bus.tank1_fire   = fire_p1[0];
   assign bus.tank2_fire   = fire_p1[1];
endmodule
